// File: rtl/periph_tx_fifo_pkg.sv
// Shared constants for the TX FIFO peripheral: register map, bit positions and window decode.
// Also imported by the CPU-side address decoder.
package periph_tx_fifo_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'h0000_0200;
  localparam logic [31:0] PERIPH_MASK = 32'hFFFF_FFF0;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DRAINED = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_EN      = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;

  // Byte lanes whose write enable is low are forced to 0x00.
  function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] we);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/periph_tx_fifo_sync_fifo.sv
// Single-clock FIFO with flush. Pushes when full and pops when empty are ignored.
// A flush discards any push or pop presented in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DW-1:0]              din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DW-1:0]              head
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; empty/count gate every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/periph_tx_fifo.sv
// Memory-mapped TX FIFO peripheral: CPU pushes words via TXDATA, a valid/ready consumer drains them.
// Exposes STATUS, CTRL (enable/flush/clear-overflow) and a wrapping drained-word counter.
module periph_tx_fifo
  import periph_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    we,
  output logic [31:0]   rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    sel;
  logic          wr, push, pop, ctrl_wr, flush, clr_ovf, overflow_hit;
  logic          full, empty, enable, overflow;
  logic [AW:0]   count;
  logic [31:0]   drained, status;
  logic [DW-1:0] head;
  logic          unused_addr;

  assign sel         = addr[3:2];
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign wr           = ce & (we != 4'h0);
  assign push         = wr & (sel == REG_TXDATA);
  assign ctrl_wr      = wr & (sel == REG_CTRL) & we[0];
  assign flush        = ctrl_wr & wdata[CTRL_FLUSH];
  assign clr_ovf      = ctrl_wr & wdata[CTRL_CLR_OVF];
  assign overflow_hit = push & full;

  assign out_valid = enable & ~empty;
  assign out_data  = head;
  assign pop       = out_valid & out_ready;

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (DW'(lane_mask(wdata, we))),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // A rejected push sets overflow even when a clear arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      overflow <= 1'b0;
      drained  <= '0;
    end else begin
      if (ctrl_wr) enable <= wdata[CTRL_EN];
      if (overflow_hit)  overflow <= 1'b1;
      else if (clr_ovf)  overflow <= 1'b0;
      if (wr && sel == REG_DRAINED) drained <= '0;
      else if (pop && !flush)       drained <= drained + 32'd1;
    end
  end

  always_comb begin
    status                 = '0;
    status[ST_FULL]        = full;
    status[ST_EMPTY]       = empty;
    status[ST_OVF]         = overflow;
    status[ST_EN]          = enable;
    status[ST_CNT_LSB +: 8] = 8'(count);
  end

  // NOTE: every path assigns rdata, and the default covers ce=0, so no latch is inferred.
  always_comb begin
    rdata = '0;
    if (ce) begin
      case (sel)
        REG_STATUS:  rdata = status;
        REG_CTRL:    rdata = {31'b0, enable};
        REG_DRAINED: rdata = drained;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/periph_tx_fifo.md
Name: periph_tx_fifo

Overview:
- Memory-mapped output-FIFO peripheral in the 16-byte peripheral window 0x200–0x20F, selected by the CPU-side address decoder's peripheral chip-enable.
- CPU stores to TXDATA push 32-bit words into a FIFO.
- A downstream consumer drains the FIFO over a valid/ready stream; status and a drained-word counter are readable by the CPU.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- DW, 32, data width of the bus and the stream.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- ce  in  1  peripheral chip-enable from the address decoder
- addr  in  32  byte address; only addr[3:2] decoded
- wdata  in  32  CPU write data
- we  in  4  per-byte write enables
- rdata  out  32  CPU read data, combinational
- out_data  out  DW  FIFO head word
- out_valid  out  1  head valid toward consumer
- out_ready  in  1  consumer accepts head

Behaviour:
- Register map (addr[3:2]):
  - 0 TXDATA: write-only; reads return 0.
  - 1 STATUS: read-only.
    - bit0 full
    - bit1 empty
    - bit2 overflow (sticky)
    - bit3 enable
    - bits[15:8] count
    - other bits 0
  - 2 CTRL: read returns {31'b0, enable}. Writes act only when we[0]=1:
    - bit0 → enable
    - bit1 = flush (self-clearing)
    - bit2 = clear overflow (self-clearing)
  - 3 DRAINED: 32-bit count of words drained; wraps 0xFFFFFFFF→0; any write with we≠0 clears it to 0.
- Write strobe: wr = ce & (we≠0). Inactive when ce=0 regardless of we.
- Push:
  - Occurs on wr to TXDATA; pushed word = wdata with lanes whose we bit is 0 forced to 0x00.
  - Push when full (count==DEPTH at start of cycle) is discarded and sets overflow, even if a pop occurs in the same cycle.
- Pop:
  - Condition: pop = out_valid & out_ready.
  - out_valid = enable & ~empty; out_data = head entry (0 when empty).
  - Head advances on the clock edge after pop; DRAINED increments by 1 per pop.
- Simultaneous push and pop (not full): both take effect; count unchanged.
- Flush:
  - Pointers and count go to 0 on the next edge.
  - Any same-cycle push and pop are discarded; DRAINED does not increment.
  - overflow unaffected unless the CTRL bit2 clear is in the same write.
- Clear overflow and a rejected push in the same cycle: set wins (overflow=1).
- Reads:
  - rdata = selected register when ce=1, else 0.
  - Combinational, reflecting pre-edge state; a read concurrent with a write returns the old value.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits, zero-extended into STATUS[15:8].
- Reset (synchronous, dominates all other inputs, mid-operation included):
  - count=0, pointers=0, overflow=0, enable=0, DRAINED=0.
  - Hence out_valid=0, out_data=0, STATUS reads 0x00000002.
  - FIFO storage contents need not be reset.
- Latency: a word pushed at edge N is presented on out_data/out_valid after edge N (same cycle the CPU sees empty=0), provided enable=1.

Decomposition:
- Shared package holds:
  - register offsets REG_TXDATA=0, REG_STATUS=1, REG_CTRL=2, REG_DRAINED=3
  - STATUS/CTRL bit-position constants
  - PERIPH_BASE=32'h200 and PERIPH_MASK=32'hFFFFFFF0 (shared with the decoder)
- One natural sub-module: sync_fifo (DEPTH, DW; push, pop, flush, full, empty, count, head).
- The register/bus logic stays in periph_tx_fifo.

Test Plan:
- Reset, then read STATUS (ce=1, addr=0x204) → rdata=0x00000002; out_valid=0; DRAINED reads 0.
- Enable=0; push 0xA1,0xA2,0xA3 (we=4'hF) → STATUS=0x00000300, out_valid=0. Write CTRL=1; hold out_ready=1 → out_data 0xA1,0xA2,0xA3 on 3 consecutive cycles, then out_valid=0, DRAINED=3.
- Enable=0, push 9 words with DEPTH=8 → 9th rejected, STATUS=0x00000805 (count 8, full, overflow). Write CTRL=0x4 → overflow=0. Flush (CTRL=0x2) → STATUS=0x00000002.
- Partial write: we=4'b0101, wdata=0xDEADBEEF to TXDATA → drained word 0x00AD00EF.
- Full FIFO, enable=1, out_ready=1, push in the same cycle → pop occurs, push rejected, overflow=1, count=7. Non-full: simultaneous push and pop keeps count constant.
- Push with ce=0, we=4'hF → no change. Assert reset mid-drain with count=5 → next cycle out_valid=0, STATUS=0x00000002, DRAINED=0.
